// File: rtl/pair_proc.sv
// rtl/pair_proc.sv - frame loader with pairwise arithmetic and registered result RAM
module pair_proc #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [W-1:0]                   in_data,
    input  logic [1:0]                     mode,
    output logic                           busy,
    output logic                           done,
    output logic                           ovf,
    input  logic [$clog2(DEPTH/2)-1:0]     rd_addr,
    output logic [W-1:0]                   rd_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int RW = $clog2(DEPTH / 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PROC = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [AW-1:0]   load_cnt;
    logic [AW:0]     proc_cnt;
    logic [1:0]      mode_q;
    logic            accept;

    logic [W-1:0]    ram_a [DEPTH];
    logic [W-1:0]    ram_b [DEPTH/2];
    logic [AW-1:0]   wr_addr_a;
    logic [W-1:0]    rd_word_q;
    logic [W-1:0]    dly_word_q;

    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W:0]      pair_sum;
    logic            a_gt_b;
    logic [W-1:0]    abs_diff;
    logic [W-1:0]    pair_res;
    logic            pair_carry;
    logic            pair_we;
    logic [AW-1:0]   pair_half;
    logic [RW-1:0]   pair_addr;

    assign accept = in_valid & in_ready;

    // Next-state logic and state-decoded handshake/status outputs
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (accept && (load_cnt == AW'(DEPTH - 1))) begin
                    state_d = PROC;
                end
            end
            PROC: begin
                busy = 1'b1;
                if (proc_cnt == (AW + 1)'(DEPTH)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register, load/process counters, latched mode and sticky overflow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            load_cnt <= '0;
            proc_cnt <= '0;
            mode_q   <= 2'd0;
            ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    proc_cnt <= '0;
                    if (accept) begin
                        load_cnt <= AW'(1);
                        mode_q   <= mode;
                        ovf      <= 1'b0;
                    end
                end
                LOAD: begin
                    proc_cnt <= '0;
                    if (accept) begin
                        // DEPTH is a power of two, so the last beat wraps this to 0
                        load_cnt <= load_cnt + AW'(1);
                    end
                end
                PROC: begin
                    proc_cnt <= proc_cnt + (AW + 1)'(1);
                    if (pair_we && pair_carry) begin
                        ovf <= 1'b1;
                    end
                end
                DONE: begin
                    proc_cnt <= '0;
                end
                default: begin
                    proc_cnt <= '0;
                end
            endcase
        end
    end

    // The first beat of a frame always lands in A[0], whatever the counter says
    assign wr_addr_a = (state_q == IDLE) ? '0 : load_cnt;

    // Sample RAM write port (contents are deliberately not reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            ram_a[wr_addr_a] <= in_data;
        end
    end

    // Synchronous sample read plus one-word delay so each pair is visible together
    always_ff @(posedge clk) begin
        if (state_q == PROC) begin
            rd_word_q  <= ram_a[proc_cnt[AW-1:0]];
            dly_word_q <= rd_word_q;
        end
    end

    // Pair arithmetic: a is the older (even) sample, b the newer (odd) one
    always_comb begin
        op_a       = dly_word_q;
        op_b       = rd_word_q;
        pair_sum   = {1'b0, op_a} + {1'b0, op_b};
        a_gt_b     = (op_a > op_b);
        abs_diff   = a_gt_b ? (op_a - op_b) : (op_b - op_a);
        pair_res   = pair_sum[W-1:0];
        pair_carry = 1'b0;
        case (mode_q)
            2'd0: begin
                if (a_gt_b) begin
                    pair_res = op_a - op_b;
                end else begin
                    pair_res   = pair_sum[W-1:0];
                    pair_carry = pair_sum[W];
                end
            end
            2'd1: begin
                pair_res = abs_diff;
            end
            2'd2: begin
                pair_res   = pair_sum[W] ? {W{1'b1}} : pair_sum[W-1:0];
                pair_carry = pair_sum[W];
            end
            default: begin
                pair_res   = pair_sum[W-1:0];
                pair_carry = pair_sum[W];
            end
        endcase
    end

    // A pair is complete on every even, non-zero process count; B index is count/2-1
    assign pair_we   = (state_q == PROC) && (proc_cnt != '0) && !proc_cnt[0];
    assign pair_half = proc_cnt[AW:1] - AW'(1);
    assign pair_addr = pair_half[RW-1:0];

    // Result RAM write port (holds the last frame until the next PROC overwrites it)
    always_ff @(posedge clk) begin
        if (pair_we) begin
            ram_b[pair_addr] <= pair_res;
        end
    end

    // Registered result read; a same-cycle write is not forwarded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= ram_b[rd_addr];
        end
    end

endmodule

// File: tb/tb_pair_proc.sv
// tb/tb_pair_proc.sv - self-checking bench for pair_proc with directed and random frames
module tb_pair_proc;

    localparam int W     = 8;
    localparam int DEPTH = 8;
    localparam int NP    = DEPTH / 2;
    localparam int MAXV  = (1 << W) - 1;

    logic         clk      = 1'b0;
    logic         reset    = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data  = '0;
    logic [1:0]   mode     = 2'd0;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [1:0]   rd_addr  = 2'd0;
    logic [W-1:0] rd_data;

    int checks = 0;
    int errors = 0;

    int smp   [DEPTH];
    int exp_b [NP];
    int exp_ovf;
    int old_b0;
    bit have_old = 1'b0;

    pair_proc #(.W(W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .mode     (mode),
        .busy     (busy),
        .done     (done),
        .ovf      (ovf),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: results straight from the pair rules on the sample list
    task automatic model(input int m);
        int a;
        int b;
        exp_ovf = 0;
        for (int j = 0; j < NP; j++) begin
            a = smp[2*j];
            b = smp[2*j+1];
            case (m)
                0: begin
                    if (a > b) exp_b[j] = a - b;
                    else begin
                        exp_b[j] = (a + b) % (MAXV + 1);
                        if (a + b > MAXV) exp_ovf = 1;
                    end
                end
                1: exp_b[j] = (a > b) ? a - b : b - a;
                2: begin
                    exp_b[j] = (a + b > MAXV) ? MAXV : a + b;
                    if (a + b > MAXV) exp_ovf = 1;
                end
                default: begin
                    exp_b[j] = (a + b) % (MAXV + 1);
                    if (a + b > MAXV) exp_ovf = 1;
                end
            endcase
        end
    endtask

    task automatic set_samples(input int s0, input int s1, input int s2, input int s3,
                               input int s4, input int s5, input int s6, input int s7);
        smp[0] = s0; smp[1] = s1; smp[2] = s2; smp[3] = s3;
        smp[4] = s4; smp[5] = s5; smp[6] = s6; smp[7] = s7;
    endtask

    task automatic set_expect(input int b0, input int b1, input int b2, input int b3, input int o);
        exp_b[0] = b0; exp_b[1] = b1; exp_b[2] = b2; exp_b[3] = b3;
        exp_ovf = o;
    endtask

    // Load one frame, then follow PROC/DONE cycle by cycle
    task automatic run_frame(input string tag, input int m, input bit gaps, input bit junk);
        int n;
        for (int i = 0; i < DEPTH; i++) begin
            if (gaps && i > 0) begin
                in_valid = 1'b0;
                in_data  = W'($urandom);
                @(posedge clk); #1;
            end
            chk({tag, "_ready_load"}, in_ready, 1);
            in_valid = 1'b1;
            in_data  = smp[i][W-1:0];
            mode     = (i == 0) ? 2'(m) : 2'((m + 1 + $urandom_range(0, 2)) % 4);
            @(posedge clk); #1;
        end
        in_valid = junk;
        in_data  = W'($urandom);
        rd_addr  = 2'd0;
        n = 0;
        while (n < 40) begin
            n++;
            if (n == 4 && have_old) chk({tag, "_rd_old_b0"}, rd_data, old_b0);
            if (n == 5) chk({tag, "_rd_new_b0"}, rd_data, exp_b[0]);
            if (done) break;
            if (n <= DEPTH + 1) chk({tag, "_proc_ready_busy"}, {in_ready, busy}, 2'b01);
            in_data = W'($urandom);
            @(posedge clk); #1;
        end
        chk({tag, "_done_latency"}, n, DEPTH + 2);
        chk({tag, "_done_state"}, {done, busy, in_ready}, 3'b110);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_after_done"}, {done, busy, in_ready}, 3'b001);
    endtask

    task automatic check_results(input string tag);
        for (int j = 0; j < NP; j++) begin
            rd_addr = 2'(j);
            @(posedge clk); #1;
            chk({tag, "_b"}, rd_data, exp_b[j]);
        end
        chk({tag, "_ovf"}, ovf, exp_ovf);
        old_b0   = exp_b[0];
        have_old = 1'b1;
    endtask

    initial begin
        int m;

        #12;
        chk("reset_outputs", {in_ready, busy, done, ovf}, 4'b1000);
        chk("reset_rd_data", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        set_samples(10, 3, 5, 9, 200, 100, 7, 7);
        set_expect(7, 14, 100, 14, 0);
        run_frame("m0", 0, 1'b0, 1'b0);
        check_results("m0");

        set_expect(7, 4, 100, 0, 0);
        run_frame("m1", 1, 1'b0, 1'b0);
        check_results("m1");

        set_expect(13, 14, 255, 14, 1);
        run_frame("m2", 2, 1'b0, 1'b0);
        check_results("m2");

        set_samples(100, 200, 0, 0, 0, 0, 0, 0);
        set_expect(44, 0, 0, 0, 1);
        run_frame("m0_wrap", 0, 1'b0, 1'b0);
        check_results("m0_wrap");

        set_samples(10, 3, 5, 9, 200, 100, 7, 7);
        set_expect(7, 14, 100, 14, 0);
        run_frame("gaps", 0, 1'b1, 1'b1);
        check_results("gaps");

        set_samples(100, 200, 0, 0, 0, 0, 0, 0);
        set_expect(44, 0, 0, 0, 1);
        run_frame("ovf_set", 0, 1'b0, 1'b0);
        check_results("ovf_set");

        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            mode     = 2'd3;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset    = 1'b0;
        #2;
        chk("midload_reset_outputs", {in_ready, busy, done, ovf}, 4'b1000);
        chk("midload_reset_rd_data", rd_data, 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        set_samples(10, 3, 5, 9, 200, 100, 7, 7);
        set_expect(7, 4, 100, 0, 0);
        run_frame("after_reset", 1, 1'b0, 1'b0);
        check_results("after_reset");

        for (int f = 0; f < 6; f++) begin
            m = int'($urandom_range(0, 3));
            for (int i = 0; i < DEPTH; i++) smp[i] = int'($urandom_range(0, MAXV));
            model(m);
            run_frame("rand", m, (f % 2) == 1, (f % 3) == 0);
            check_results("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pair_proc.md
PAIR_PROC -- requirements
Module: pair_proc

Interface
REQ-001 The block SHALL be clocked by one clock `clk`; reset is asynchronous and active-low, on port `reset`.
REQ-002 Parameter W, default 8: sample and result width in bits, W >= 2.
REQ-003 Parameter DEPTH, default 8: samples per frame; SHALL be an even power of two, >= 4; result count DEPTH/2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 in_valid  input  1  sample offered.
REQ-007 in_ready  output  1  sample accepted when in_valid & in_ready.
REQ-008 in_data  input  W  sample value, unsigned.
REQ-009 mode  input  2  op select, sampled with first beat of a frame.
REQ-010 busy  output  1  high while a frame is being processed.
REQ-011 done  output  1  one-cycle pulse when all results are written.
REQ-012 ovf  output  1  frame overflow/saturation flag.
REQ-013 rd_addr  input  log2(DEPTH/2)  result read address.
REQ-014 rd_data  output  W  result at rd_addr, registered.

Function
REQ-015 FSM states SHALL be IDLE, LOAD, PROC, DONE.
REQ-016 in_ready SHALL be 1 in IDLE and LOAD, 0 in PROC and DONE.
REQ-017 IDLE->LOAD on first accepted beat; that beat SHALL be written to sample RAM A[0] and mode latched as mode_q.
REQ-018 In LOAD each accepted beat SHALL write A[k], k incrementing by 1; in_valid low stalls without state change.
REQ-019 LOAD->PROC on the edge accepting sample DEPTH-1; the load counter SHALL wrap to 0.
REQ-020 PROC SHALL read A[0..DEPTH-1], one address per cycle, synchronous read with 1-cycle latency, and hold the previous read word in a delay register.
REQ-021 For each pair (a=A[2j], b=A[2j+1]) result B[j] SHALL be:
- mode 0: a>b ? a-b : a+b
- mode 1: |a-b|
- mode 2: min(a+b, 2^W-1)
- mode 3: a+b
Results are modulo 2^W except mode 2.
REQ-022 ovf SHALL clear when a frame starts (IDLE->LOAD) and set sticky when any add in mode 0/3 carries out or mode 2 clamps.
REQ-023 PROC SHALL last exactly DEPTH+1 cycles, then DONE for exactly 1 cycle with done=1, then IDLE.
REQ-024 done SHALL be high in the (DEPTH+2)th cycle after the edge accepting the last sample.
REQ-025 busy SHALL be 1 in PROC and DONE, 0 otherwise.
REQ-026 Reads: rd_data SHALL equal B[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-027 A read of an address written in the same cycle SHALL return the old value.
REQ-028 B SHALL hold the last frame's results until overwritten by the next frame's PROC.
REQ-029 mode changes after the first beat SHALL not affect the current frame.

Reset
REQ-030 reset low SHALL immediately force IDLE, counters 0, done=0, busy=0, ovf=0, rd_data=0, in_ready=1.
REQ-031 RAM A/B contents SHALL NOT be reset; B reads before the first frame are undefined.
REQ-032 Reset asserted mid-LOAD or mid-PROC SHALL abandon the frame; the next accepted beat after release SHALL be treated as A[0].

Verification (W=8, DEPTH=8)
REQ-033 mode 0, samples 10,3,5,9,200,100,7,7 -> B = 7,14,100,14; ovf=0; done exactly 10 cycles after last beat.
REQ-034 mode 1, same samples -> B = 7,4,100,0; ovf=0.
REQ-035 mode 2, same samples -> B = 13,14,255,14; ovf=1.
REQ-036 mode 0, samples 100,200 then six zeros -> B[0]=44, ovf=1; mode toggled after beat 0 has no effect.
REQ-037 in_valid toggled every other cycle during LOAD -> same results as REQ-033; in_ready=0 throughout PROC/DONE and beats offered then are ignored.
REQ-038 reset pulsed after 5 beats, then full 8-beat frame of REQ-034 -> B = 7,4,100,0; done pulses once.
